// File: rtl/oh_gate2_bist.sv
// oh_gate2_bist -- built-in self-test sequencer for two-input standard cells.
//
// Drives the cell inputs a/b through a Gray-ordered sweep (00, 01, 11, 10),
// repeated NLOOPS times. Each vector is held for SETTLE cycles. The cell
// output z is then compared against TRUTH[{a,b}]. A saturating mismatch
// count and sticky per-vector failure flags are kept for the run.
//
// Optional build macro: OH_GATE2_BIST_SYNC_EN
//   defined   : z passes through a 2-flop synchronizer before comparison.
//               The cell then gets SETTLE-2 cycles to settle, and SETTLE must
//               be at least 3.
//   undefined : z is sampled directly on the sample edge.
// Cycle timing seen at the ports is the same in both builds.
//
// Parameters:
//   TRUTH    expected z per vector index {a,b} (default 4'b0111 = NAND2)
//   SETTLE   cycles from drive edge to sample edge for each vector
//   NLOOPS   number of full 4-vector sweeps per run
// Ports:
//   clk      clock
//   reset    asynchronous active-high reset
//   start    run request level; acted on only in IDLE or DONE
//   a, b     registered drive to the cell inputs
//   z        cell output under test (may be asynchronous to clk)
//   busy     high while a run is in progress
//   done     high from run completion until the next accepted start or reset
//   pass     done and errcnt == 0
//   errcnt   saturating mismatch count for the current or last run
//   fail_vec sticky per-vector mismatch flags for the current or last run

module oh_gate2_bist #(
    parameter logic [3:0] TRUTH  = 4'b0111,
    parameter int         SETTLE = 4,
    parameter int         NLOOPS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       a,
    output logic       b,
    input  logic       z,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] errcnt,
    output logic [3:0] fail_vec
);

    localparam int            SW         = $clog2(SETTLE + 1);
    localparam int            LW         = $clog2(NLOOPS + 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE);
    localparam logic [LW-1:0] LAST_LOOP  = LW'(NLOOPS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state;
    logic [SW-1:0] settle_cnt;   // 1..SETTLE within the current vector
    logic [1:0]    step;         // binary position of the vector within a loop
    logic [LW-1:0] loop_cnt;     // completed loops in this run
    logic          z_cmp;        // value of z used for comparison

`ifdef OH_GATE2_BIST_SYNC_EN
    logic z_meta;
    logic z_sync;

    if (SETTLE < 3) begin : g_settle_check
        $error("oh_gate2_bist: SETTLE must be >= 3 when OH_GATE2_BIST_SYNC_EN is defined");
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            z_meta <= 1'b0;
            z_sync <= 1'b0;
        end else begin
            z_meta <= z;
            z_sync <= z_meta;
        end
    end

    assign z_cmp = z_sync;
`else
    assign z_cmp = z;
`endif

    logic [1:0] vec;
    logic       mismatch;
    logic       last_vec;
    logic [1:0] step_next;
    logic [1:0] gray_next;
    logic [7:0] err_next;

    assign vec       = {a, b};
    assign mismatch  = (z_cmp != TRUTH[vec]);
    assign last_vec  = (step == 2'd3) && (loop_cnt == LAST_LOOP);
    assign step_next = step + 2'd1;
    // Binary-to-Gray so that exactly one of a/b toggles per step.
    assign gray_next = {step_next[1], step_next[1] ^ step_next[0]};
    // Saturating increment. This is only committed on a sample edge.
    assign err_next  = (mismatch && errcnt != 8'hFF) ? errcnt + 8'd1 : errcnt;

    // NOTE: every state element uses non-blocking assignment, so all of them
    // update together from the values present before the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            errcnt     <= 8'd0;
            fail_vec   <= 4'd0;
            settle_cnt <= SW'(1);
            step       <= 2'd0;
            loop_cnt   <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        // The accept edge clears the old results and drives
                        // vector 00 at the same time.
                        state      <= RUN;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        errcnt     <= 8'd0;
                        fail_vec   <= 4'd0;
                        a          <= 1'b0;
                        b          <= 1'b0;
                        settle_cnt <= SW'(1);
                        step       <= 2'd0;
                        loop_cnt   <= '0;
                    end
                end
                RUN: begin
                    if (settle_cnt == SETTLE_MAX) begin
                        errcnt <= err_next;
                        if (mismatch) begin
                            fail_vec[vec] <= 1'b1;
                        end
                        if (last_vec) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_next == 8'd0);
                            a     <= 1'b0;
                            b     <= 1'b0;
                        end else begin
                            step       <= step_next;
                            a          <= gray_next[1];
                            b          <= gray_next[0];
                            settle_cnt <= SW'(1);
                            if (step == 2'd3) begin
                                loop_cnt <= loop_cnt + LW'(1);
                            end
                        end
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oh_gate2_bist.sv
// Testbench for oh_gate2_bist. Three instances with SETTLE=2 and
// NLOOPS = 1, 3 and 100 share clk/reset/start. Each instance sees its own
// cell model on z: a good NAND2, stuck-at-1 or stuck-at-0.
// For each run, the expected per-cycle port values are pushed to a queue
// when start is driven. They are popped and compared on every falling edge.

module tb_oh_gate2_bist;

    localparam int         SETTLE     = 2;
    localparam logic [3:0] TRUTH_NAND = 4'b0111;

    localparam int MODE_GOOD = 0;
    localparam int MODE_SA1  = 1;
    localparam int MODE_SA0  = 2;

    typedef struct packed {
        logic       a;
        logic       b;
        logic       busy;
        logic       done;
        logic       pass;
        logic [7:0] err;
        logic [3:0] fv;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    int         z_mode;
    logic [2:0] a_v, b_v, z_v, busy_v, done_v, pass_v;
    logic [7:0] err_v [3];
    logic [3:0] fv_v  [3];

    int   errors = 0;
    int   checks = 0;
    obs_t sb[$];

    always #5 clk = ~clk;

    function automatic logic cell_z(input int mode, input logic ca, input logic cb);
        case (mode)
            MODE_SA1: return 1'b1;
            MODE_SA0: return 1'b0;
            default:  return ~(ca & cb);
        endcase
    endfunction

    function automatic logic [1:0] gray_of(input int k);
        case (k % 4)
            0:       return 2'b00;
            1:       return 2'b01;
            2:       return 2'b11;
            default: return 2'b10;
        endcase
    endfunction

    assign z_v[0] = cell_z(z_mode, a_v[0], b_v[0]);
    assign z_v[1] = cell_z(z_mode, a_v[1], b_v[1]);
    assign z_v[2] = cell_z(z_mode, a_v[2], b_v[2]);

    oh_gate2_bist #(.TRUTH(TRUTH_NAND), .SETTLE(SETTLE), .NLOOPS(1)) u_n1 (
        .clk(clk), .reset(reset), .start(start), .a(a_v[0]), .b(b_v[0]), .z(z_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]), .errcnt(err_v[0]), .fail_vec(fv_v[0])
    );
    oh_gate2_bist #(.TRUTH(TRUTH_NAND), .SETTLE(SETTLE), .NLOOPS(3)) u_n3 (
        .clk(clk), .reset(reset), .start(start), .a(a_v[1]), .b(b_v[1]), .z(z_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]), .errcnt(err_v[1]), .fail_vec(fv_v[1])
    );
    oh_gate2_bist #(.TRUTH(TRUTH_NAND), .SETTLE(SETTLE), .NLOOPS(100)) u_n100 (
        .clk(clk), .reset(reset), .start(start), .a(a_v[2]), .b(b_v[2]), .z(z_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]), .errcnt(err_v[2]), .fail_vec(fv_v[2])
    );

    function automatic obs_t observe(input int sel);
        obs_t o;
        o.a    = a_v[sel];
        o.b    = b_v[sel];
        o.busy = busy_v[sel];
        o.done = done_v[sel];
        o.pass = pass_v[sel];
        o.err  = err_v[sel];
        o.fv   = fv_v[sel];
        return o;
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Starts a run on all instances and checks instance 'sel' every cycle
    // against the scoreboard. poke_at >= 0 pulses start at that cycle of the
    // run. abort_at >= 0 stops checking after that cycle, leaving the DUT
    // mid-run.
    task automatic run_sweep(input int sel, input int nloops, input int mode,
                             input int poke_at, input int abort_at);
        int         total;
        int         nerr;
        int         j;
        logic [3:0] fv;
        logic [1:0] v;
        obs_t       e;
        obs_t       o;
        total  = 4 * nloops * SETTLE;
        z_mode = mode;
        nerr   = 0;
        fv     = 4'd0;
        // Entry j is the expected state after edge E0+j, where E0 is the
        // accept edge.
        for (int k = 0; k <= total; k++) begin
            if (k > 0 && (k % SETTLE) == 0) begin
                v = gray_of(k / SETTLE - 1);
                if (cell_z(mode, v[1], v[0]) != TRUTH_NAND[v]) begin
                    nerr++;
                    fv[v] = 1'b1;
                end
            end
            e.err = (nerr > 255) ? 8'd255 : 8'(nerr);
            e.fv  = fv;
            if (k < total) begin
                v      = gray_of(k / SETTLE);
                e.a    = v[1];
                e.b    = v[0];
                e.busy = 1'b1;
                e.done = 1'b0;
                e.pass = 1'b0;
            end else begin
                e.a    = 1'b0;
                e.b    = 1'b0;
                e.busy = 1'b0;
                e.done = 1'b1;
                e.pass = (nerr == 0);
            end
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b1;
        j = 0;
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            o = observe(sel);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL sweep sel=%0d cyc=%0d got a=%b b=%b busy=%b done=%b pass=%b err=%0d fv=%b want a=%b b=%b busy=%b done=%b pass=%b err=%0d fv=%b",
                         sel, j, o.a, o.b, o.busy, o.done, o.pass, o.err, o.fv,
                         e.a, e.b, e.busy, e.done, e.pass, e.err, e.fv);
            end
            start = (j == poke_at);
            if (j == abort_at) begin
                sb.delete();
            end
            j++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        reset  = 1'b1;
        start  = 1'b0;
        z_mode = MODE_GOOD;
        #1;
        for (int i = 0; i < 3; i++) begin
            o = observe(i);
            checks++;
            if (o !== '0) begin
                errors++;
                $display("FAIL reset_values inst=%0d got %h want 0", i, o);
            end
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_ideal_nand();
        apply_reset();
        run_sweep(0, 1, MODE_GOOD, -1, -1);
        checks++;
        if (pass_v[0] !== 1'b1 || err_v[0] !== 8'd0 || fv_v[0] !== 4'b0000) begin
            errors++;
            $display("FAIL ideal_nand got pass=%b err=%0d fv=%b want pass=1 err=0 fv=0000",
                     pass_v[0], err_v[0], fv_v[0]);
        end
    endtask

    task automatic test_stuck1();
        apply_reset();
        run_sweep(1, 3, MODE_SA1, -1, -1);
        checks++;
        if (pass_v[1] !== 1'b0 || err_v[1] !== 8'd3 || fv_v[1] !== 4'b1000) begin
            errors++;
            $display("FAIL stuck1 got pass=%b err=%0d fv=%b want pass=0 err=3 fv=1000",
                     pass_v[1], err_v[1], fv_v[1]);
        end
    endtask

    task automatic test_stuck0_sat();
        apply_reset();
        run_sweep(2, 100, MODE_SA0, -1, -1);
        checks++;
        if (pass_v[2] !== 1'b0 || err_v[2] !== 8'd255 || fv_v[2] !== 4'b0111) begin
            errors++;
            $display("FAIL stuck0_sat got pass=%b err=%0d fv=%b want pass=0 err=255 fv=0111",
                     pass_v[2], err_v[2], fv_v[2]);
        end
    endtask

    task automatic test_start_while_busy();
        apply_reset();
        run_sweep(0, 1, MODE_GOOD, 3, -1);
    endtask

    task automatic test_restart_from_done();
        apply_reset();
        run_sweep(0, 1, MODE_SA1, -1, -1);
        // The first entry of the second run checks that the flags cleared on
        // the accept edge.
        run_sweep(0, 1, MODE_GOOD, -1, -1);
    endtask

    task automatic test_reset_mid_run();
        obs_t o;
        apply_reset();
        // Loop 1, vector 11 is vector 6, which is driven at cycle 12.
        // Cycle 13 is therefore mid-vector.
        run_sweep(1, 3, MODE_SA0, -1, 13);
        reset = 1'b1;
        #1;
        o = observe(1);
        checks++;
        if (o !== '0) begin
            errors++;
            $display("FAIL reset_mid_run got a=%b b=%b busy=%b done=%b err=%0d fv=%b want all 0",
                     o.a, o.b, o.busy, o.done, o.err, o.fv);
        end
        @(negedge clk);
        reset = 1'b0;
        run_sweep(1, 3, MODE_GOOD, -1, -1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_ideal_nand();
        test_stuck1();
        test_stuck0_sat();
        test_start_while_busy();
        test_restart_from_done();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/oh_gate2_bist.md
# oh_gate2_bist

Built-in self-test sequencer for two-input standard cells (oh_nand2 and siblings). It drives the cell's `a`/`b` inputs through an exhaustive Gray-ordered vector sweep, samples the cell output `z` after a programmable settle time, and compares each sample against a parameterised truth table. It accumulates an error count and per-vector failure flags. It sits next to the cell under test in characterization and silicon-debug wrappers, on the cell's input side, and observes the cell's output.

## Interface
- `TRUTH`, 4'b0111, expected `z` per vector index `{a,b}`: bit *i* is the expected `z` for `{a,b}` = *i*. The default is NAND2.
- `SETTLE`, 4, cycles from drive to sample per vector. Minimum is 1, or 3 when `OH_GATE2_BIST_SYNC_EN` is defined.
- `NLOOPS`, 1, number of full 4-vector sweeps per run. Minimum is 1.
- `clk`  input  1  clock.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  run request; sampled on rising edge of `clk`.
- `a`  output  1  drive to cell input a.
- `b`  output  1  drive to cell input b.
- `z`  input  1  cell output under test; may be asynchronous to `clk`.
- `busy`  output  1  high while a run is in progress.
- `done`  output  1  high after run completion, until next accepted `start` or `reset`.
- `pass`  output  1  `done` && `errcnt`==0.
- `errcnt`  output  8  saturating mismatch count for the current or last run.
- `fail_vec`  output  4  sticky per-index mismatch flags for the current or last run.

## Operation
- **Reset values:** a=0, b=0, busy=0, done=0, pass=0, errcnt=0, fail_vec=0, FSM=IDLE.
- **FSM states:** IDLE, RUN, DONE.
- **IDLE:**
  - `a`/`b` held at 0.
  - `start`=1 → RUN.
- **RUN:**
  - Vector order per loop: `{a,b}` = 00, 01, 11, 10, then wrap to 00 for the next loop.
  - A settle counter counts 1..SETTLE.
  - At count SETTLE, `z` (or its synchronized copy) is compared against `TRUTH[{a,b}]`.
  - On mismatch: `errcnt` += 1, saturating at 255; `fail_vec[{a,b}]` set.
  - On the same edge, the next vector is driven.
  - After the last vector of loop NLOOPS is sampled, the FSM goes to DONE and `a`/`b` return to 00.
- **DONE:**
  - `done`=1; `pass` is valid.
  - `start`=1 → clear `errcnt`, `fail_vec`, `done` and `pass`, then enter RUN.
- **start handling:**
  - `start` is a level; it is only acted on in IDLE or DONE.
  - `start` while `busy` is ignored.
  - `start` held high in DONE restarts every time DONE is entered. This is the intended free-run mode.
- **Loop counter:** width `$clog2(NLOOPS+1)`; wraps only via the FSM exit, never arithmetically.
- **Reset mid-run:** all outputs return to reset values immediately, asynchronously. The partial run is discarded and no `done` is produced.

## Timing
- **Start edge:** at the rising edge E0 where `start` is sampled in IDLE/DONE, the block sets `busy`=1 and drives vector 00 at that same edge.
- **Vector k:** driven at edge E0+k·SETTLE and sampled at edge E0+(k+1)·SETTLE. The next vector is driven at that same sample edge.
- **Run length:** `busy` is high for exactly 4·NLOOPS·SETTLE cycles.
- **Completion edge:** `done`/`pass` rise, and `busy` falls, on the final sample edge. `errcnt` includes that final sample.
- **Latency:** there is no latency from the sample edge to `errcnt`/`fail_vec`; both update on the sample edge.
- **Driver:** `a`/`b` are registered outputs with no glitches between vectors. Gray ordering guarantees a single-bit change per step.

## Configuration
- **`OH_GATE2_BIST_SYNC_EN` defined:**
  - `z` passes through a 2-flop synchronizer before comparison.
  - The effective cell settle time is SETTLE−2 cycles.
  - SETTLE<3 is a configuration error, flagged by a simulation `$error` at elaboration.
- **`OH_GATE2_BIST_SYNC_EN` undefined:**
  - `z` is sampled directly at the sample edge.
  - The cell is required to be combinationally settled within SETTLE cycles of the drive edge.
- Cycle counts visible at ports are identical in both builds.

## Test plan
- **Ideal NAND2 model:** SETTLE=2, NLOOPS=1, pulse `start`.
  - `{a,b}` = 00, 01, 11, 10 at 2-cycle spacing.
  - `busy` high for 8 cycles, then done=1, pass=1, errcnt=0, fail_vec=4'b0000.
- **Stuck-at-1 `z`:** NLOOPS=3.
  - errcnt=3, fail_vec=4'b1000, pass=0.
- **Stuck-at-0 `z` with saturation:** NLOOPS=100.
  - errcnt saturates at 255 (raw count 300), fail_vec=4'b0111, pass=0.
- **start while busy:** assert `start` 3 cycles into a run.
  - No restart; `busy` duration unchanged.
- **Restart from DONE:** assert `start` in DONE with a good cell, after a failing run.
  - Flags clear on the accept edge; new run ends with pass=1.
- **Reset mid-run:** assert `reset` mid-vector at loop 1, vector 11.
  - a=b=0, busy=0, errcnt=0 immediately, without waiting for a clock edge.
  - A subsequent `start` runs a full, correct sweep.
